// File: rtl/holo_mem_arbiter.sv
// Byte-wide memory port arbiter: round-robin between fetch and load/store,
// splitting each granted request into little-endian byte beats.
module holo_mem_arbiter #(
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        F_REQ,
    input  logic [31:0] F_ADDR,
    output logic        F_GNT,
    output logic        F_DONE,
    output logic [31:0] F_RDATA,
    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [1:0]  D_SIZE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    output logic        D_GNT,
    output logic        D_DONE,
    output logic        D_ERR,
    output logic [31:0] D_RDATA,
    output logic [31:0] MEM_ADDR,
    output logic        MEM_RE,
    output logic        MEM_WE,
    output logic [7:0]  MEM_WDATA,
    input  logic [7:0]  MEM_RDATA
);

    localparam int WCW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [WCW-1:0] WLAST =
        WCW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, DONE} state_t;

    state_t state_q, state_d;

    logic           own_d_q, we_q, err_q, last_d_q;
    logic [31:0]    base_q, wdata_q, asm_q, f_rdata_q, d_rdata_q;
    logic [1:0]     idx_q, nlast_q;
    logic [WCW-1:0] wcnt_q;

    logic        grant, pick_d, step, wait_end, last_beat;
    logic [31:0] asm_next;

    assign pick_d    = D_REQ & (~F_REQ | ~last_d_q);
    assign wait_end  = (wcnt_q == WLAST);
    assign last_beat = (idx_q == nlast_q);

    always_comb begin
        asm_next = asm_q;
        asm_next[{idx_q, 3'b000} +: 8] = MEM_RDATA;
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (F_REQ | D_REQ) begin
                    grant = 1'b1;
                    // Illegal size completes at once without touching memory
                    if (pick_d && D_SIZE == 2'b11) state_d = DONE;
                    else                           state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (WAIT_STATES > 0) begin
                    state_d = WAIT;
                end else if (!we_q) begin
                    state_d = CAPTURE;
                end else if (last_beat) begin
                    state_d = DONE;
                end else begin
                    state_d = ISSUE;
                    step    = 1'b1;
                end
            end
            WAIT: begin
                if (wait_end) begin
                    if (!we_q) begin
                        state_d = CAPTURE;
                    end else if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        step    = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                if (last_beat) begin
                    state_d = DONE;
                end else begin
                    state_d = ISSUE;
                    step    = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            own_d_q   <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            last_d_q  <= 1'b1;
            base_q    <= '0;
            wdata_q   <= '0;
            asm_q     <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
            idx_q     <= '0;
            nlast_q   <= '0;
            wcnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                own_d_q <= pick_d;
                we_q    <= pick_d & D_WE;
                err_q   <= pick_d & (D_SIZE == 2'b11);
                base_q  <= pick_d ? D_ADDR : F_ADDR;
                wdata_q <= D_WDATA;
                asm_q   <= '0;
                idx_q   <= '0;
                wcnt_q  <= '0;
                // nlast holds the index of the final beat
                if (!pick_d)              nlast_q <= 2'd3;
                else if (D_SIZE == 2'b00) nlast_q <= 2'd0;
                else if (D_SIZE == 2'b01) nlast_q <= 2'd1;
                else                      nlast_q <= 2'd3;
            end
            if (step) idx_q <= idx_q + 2'd1;
            if (state_q == WAIT) wcnt_q <= wait_end ? '0 : wcnt_q + 1'b1;
            if (state_q == CAPTURE) begin
                asm_q <= asm_next;
                if (last_beat) begin
                    if (own_d_q) d_rdata_q <= asm_next;
                    else         f_rdata_q <= asm_next;
                end
            end
            if (state_q == DONE) last_d_q <= own_d_q;
        end
    end

    logic busy, issue, done;
    assign busy  = (state_q != IDLE);
    assign issue = (state_q == ISSUE);
    assign done  = (state_q == DONE);

    assign F_GNT     = busy & ~own_d_q;
    assign D_GNT     = busy & own_d_q;
    assign F_DONE    = done & ~own_d_q;
    assign D_DONE    = done & own_d_q;
    assign D_ERR     = done & own_d_q & err_q;
    assign F_RDATA   = f_rdata_q;
    assign D_RDATA   = d_rdata_q;
    assign MEM_ADDR  = base_q + {30'b0, idx_q};
    assign MEM_RE    = issue & ~we_q;
    assign MEM_WE    = issue & we_q;
    assign MEM_WDATA = MEM_WE ? wdata_q[{idx_q, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_holo_mem_arbiter.sv
// Scoreboard bench for holo_mem_arbiter: expected beats and completions are
// queued at issue time and matched by monitors sampling on the falling edge.
module tb_holo_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        F_REQ, D_REQ, D_WE;
    logic [31:0] F_ADDR, D_ADDR, D_WDATA;
    logic [1:0]  D_SIZE;
    logic        F_GNT, F_DONE, D_GNT, D_DONE, D_ERR;
    logic [31:0] F_RDATA, D_RDATA, MEM_ADDR;
    logic        MEM_RE, MEM_WE;
    logic [7:0]  MEM_WDATA, mem_rdata;

    logic        f2_req;
    logic        f2_gnt, f2_done, d2_gnt, d2_done, d2_err;
    logic [31:0] f2_rdata, d2_rdata, m2_addr;
    logic        m2_re, m2_we;
    logic [7:0]  m2_wdata, m2_rdata;

    logic [7:0]  mem [256];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_addr, poke_data;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int          cyc;
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  wdata;
    } beat_t;

    typedef struct {
        int          cyc;
        bit          isd;
        logic [31:0] rdata;
        bit          err;
    } txn_t;

    beat_t qb[$];
    beat_t qb2[$];
    txn_t  qt[$];
    txn_t  qt2[$];

    holo_mem_arbiter #(.WAIT_STATES(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .F_REQ(F_REQ), .F_ADDR(F_ADDR), .F_GNT(F_GNT),
        .F_DONE(F_DONE), .F_RDATA(F_RDATA),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_SIZE(D_SIZE),
        .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_GNT(D_GNT),
        .D_DONE(D_DONE), .D_ERR(D_ERR), .D_RDATA(D_RDATA),
        .MEM_ADDR(MEM_ADDR), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(mem_rdata)
    );

    holo_mem_arbiter #(.WAIT_STATES(2)) u_w2 (
        .clk(clk), .rst_n(rst_n),
        .F_REQ(f2_req), .F_ADDR(32'h0), .F_GNT(f2_gnt),
        .F_DONE(f2_done), .F_RDATA(f2_rdata),
        .D_REQ(1'b0), .D_WE(1'b0), .D_SIZE(2'b00),
        .D_ADDR(32'h0), .D_WDATA(32'h0), .D_GNT(d2_gnt),
        .D_DONE(d2_done), .D_ERR(d2_err), .D_RDATA(d2_rdata),
        .MEM_ADDR(m2_addr), .MEM_RE(m2_re), .MEM_WE(m2_we),
        .MEM_WDATA(m2_wdata), .MEM_RDATA(m2_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous byte memory: read data registered on the strobe edge
    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        if (MEM_WE) mem[MEM_ADDR[7:0]] <= MEM_WDATA;
        if (MEM_RE) mem_rdata <= mem[MEM_ADDR[7:0]];
        if (m2_re) m2_rdata <= mem[m2_addr[7:0]];
    end

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    function automatic void fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
    endfunction

    function automatic void pbeat(int c, bit wr, logic [31:0] a,
                                  logic [7:0] w);
        beat_t b;
        b.cyc = c; b.wr = wr; b.addr = a; b.wdata = w;
        qb.push_back(b);
    endfunction

    function automatic void ptxn(int c, bit isd, logic [31:0] rd, bit err);
        txn_t t;
        t.cyc = c; t.isd = isd; t.rdata = rd; t.err = err;
        qt.push_back(t);
    endfunction

    function automatic void pfetch(int k, logic [31:0] a);
        for (int i = 0; i < 4; i++) pbeat(k + 1 + 2 * i, 1'b0, a + i, 8'h0);
    endfunction

    always @(negedge clk) begin : mon
        beat_t b;
        txn_t  t;
        if (rst_n) begin
            if (F_GNT | D_GNT) chk("gnt_excl", 64'(F_GNT & D_GNT), 64'(0));
            if (MEM_RE | MEM_WE) begin
                chk("strobe_excl", 64'(MEM_RE & MEM_WE), 64'(0));
                if (qb.size() == 0) begin
                    fail("unexpected_strobe");
                end else begin
                    b = qb.pop_front();
                    chk("beat_cycle", 64'(cyc), 64'(b.cyc));
                    chk("beat_we", 64'(MEM_WE), 64'(b.wr));
                    chk("beat_addr", 64'(MEM_ADDR), 64'(b.addr));
                    if (b.wr) chk("beat_wdata", 64'(MEM_WDATA), 64'(b.wdata));
                end
            end
            if (F_DONE | D_DONE) begin
                if (qt.size() == 0) begin
                    fail("unexpected_done");
                end else begin
                    t = qt.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(t.cyc));
                    chk("done_owner", 64'({F_DONE, D_DONE}),
                        64'(t.isd ? 2'b01 : 2'b10));
                    chk("done_gnt", 64'(t.isd ? D_GNT : F_GNT), 64'(1));
                    chk("rdata", 64'(t.isd ? D_RDATA : F_RDATA),
                        64'(t.rdata));
                    chk("d_err", 64'(D_ERR), 64'(t.err));
                end
            end
        end
    end

    always @(negedge clk) begin : mon2
        beat_t b;
        txn_t  t;
        if (rst_n) begin
            if (m2_re | m2_we) begin
                if (qb2.size() == 0) begin
                    fail("w2_unexpected_strobe");
                end else begin
                    b = qb2.pop_front();
                    chk("w2_beat_cycle", 64'(cyc), 64'(b.cyc));
                    chk("w2_beat_we", 64'(m2_we), 64'(b.wr));
                    chk("w2_beat_addr", 64'(m2_addr), 64'(b.addr));
                end
            end
            if (f2_done | d2_done) begin
                if (qt2.size() == 0) begin
                    fail("w2_unexpected_done");
                end else begin
                    t = qt2.pop_front();
                    chk("w2_done_cycle", 64'(cyc), 64'(t.cyc));
                    chk("w2_done_owner", 64'({f2_done, d2_done}), 64'(2'b10));
                    chk("w2_rdata", 64'(f2_rdata), 64'(t.rdata));
                end
            end
        end
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic wait_done(input int which, input int lim, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            seen = (which == 0) ? F_DONE : (which == 1) ? D_DONE : f2_done;
        end
        if (!seen) fail({nm, "_timeout"});
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_ctrl"}, 64'({F_GNT, F_DONE, D_GNT, D_DONE, D_ERR,
                              MEM_RE, MEM_WE, MEM_WDATA}), 64'(0));
        chk({nm, "_addr"}, 64'(MEM_ADDR), 64'(0));
        chk({nm, "_frdata"}, 64'(F_RDATA), 64'(0));
        chk({nm, "_drdata"}, 64'(D_RDATA), 64'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int    k;
        beat_t b;
        txn_t  t;
        rst_n = 1'b0;
        F_REQ = 1'b0; F_ADDR = '0;
        D_REQ = 1'b0; D_WE = 1'b0; D_SIZE = 2'b00;
        D_ADDR = '0; D_WDATA = '0;
        f2_req = 1'b0;
        poke(8'd0, 8'h13);
        poke(8'd1, 8'h05);
        poke(8'd2, 8'h10);
        poke(8'd3, 8'h00);
        poke(8'd8, 8'h00);
        chk_reset_outs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fetch, no wait states
        k = cyc;
        pfetch(k, 32'h0);
        ptxn(k + 9, 1'b0, 32'h0010_0513, 1'b0);
        F_ADDR = 32'h0;
        F_REQ  = 1'b1;
        wait_done(0, 30, "fetch0");
        @(posedge clk);
        #1 F_REQ = 1'b0;

        // Same fetch with two wait states per beat
        k = cyc;
        for (int i = 0; i < 4; i++) begin
            b.cyc = k + 1 + 4 * i; b.wr = 1'b0; b.addr = i; b.wdata = 8'h0;
            qb2.push_back(b);
        end
        t.cyc = k + 17; t.isd = 1'b0; t.rdata = 32'h0010_0513; t.err = 1'b0;
        qt2.push_back(t);
        f2_req = 1'b1;
        wait_done(2, 40, "fetch_w2");
        @(posedge clk);
        #1 f2_req = 1'b0;

        // SB to 0x8
        k = cyc;
        pbeat(k + 1, 1'b1, 32'h8, 8'hDD);
        ptxn(k + 2, 1'b1, 32'h0, 1'b0);
        D_WE = 1'b1; D_SIZE = 2'b00; D_ADDR = 32'h8; D_WDATA = 32'hAABBCCDD;
        D_REQ = 1'b1;
        wait_done(1, 20, "sb");
        @(posedge clk);
        #1 D_REQ = 1'b0;

        // LH across the address wrap
        poke(8'hFF, 8'h34);
        poke(8'h00, 8'h12);
        k = cyc;
        pbeat(k + 1, 1'b0, 32'hFFFF_FFFF, 8'h0);
        pbeat(k + 3, 1'b0, 32'h0, 8'h0);
        ptxn(k + 5, 1'b1, 32'h0000_1234, 1'b0);
        D_WE = 1'b0; D_SIZE = 2'b01; D_ADDR = 32'hFFFF_FFFF;
        D_REQ = 1'b1;
        wait_done(1, 20, "lh_wrap");
        @(posedge clk);
        #1 D_REQ = 1'b0;

        // Illegal size: immediate error, no strobe, load data untouched
        k = cyc;
        ptxn(k + 1, 1'b1, 32'h0000_1234, 1'b1);
        D_WE = 1'b0; D_SIZE = 2'b11; D_ADDR = 32'h10;
        D_REQ = 1'b1;
        wait_done(1, 10, "illegal");
        @(posedge clk);
        #1 D_REQ = 1'b0;

        // Contention from reset: expect F, D, F, D
        rst_n = 1'b0;
        poke(8'h00, 8'h13);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        D_WE = 1'b0; D_SIZE = 2'b00; D_ADDR = 32'h8; F_ADDR = 32'h0;
        k = cyc;
        pfetch(k, 32'h0);
        pbeat(k + 11, 1'b0, 32'h8, 8'h0);
        pfetch(k + 14, 32'h0);
        pbeat(k + 25, 1'b0, 32'h8, 8'h0);
        ptxn(k + 9, 1'b0, 32'h0010_0513, 1'b0);
        ptxn(k + 13, 1'b1, 32'h0000_00DD, 1'b0);
        ptxn(k + 23, 1'b0, 32'h0010_0513, 1'b0);
        ptxn(k + 27, 1'b1, 32'h0000_00DD, 1'b0);
        fork
            begin
                for (int r = 0; r < 2; r++) begin
                    F_REQ = 1'b1;
                    wait_done(0, 40, "tie_f");
                    @(posedge clk);
                    #1 F_REQ = 1'b0;
                    #1;
                end
            end
            begin
                for (int r = 0; r < 2; r++) begin
                    D_REQ = 1'b1;
                    wait_done(1, 40, "tie_d");
                    @(posedge clk);
                    #1 D_REQ = 1'b0;
                    #1;
                end
            end
        join

        // Reset during the third fetch beat drops the transaction
        k = cyc;
        pbeat(k + 1, 1'b0, 32'h0, 8'h0);
        pbeat(k + 3, 1'b0, 32'h1, 8'h0);
        F_ADDR = 32'h0;
        F_REQ  = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset_outs("midrst");
        F_REQ = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        pfetch(k, 32'h0);
        ptxn(k + 9, 1'b0, 32'h0010_0513, 1'b0);
        F_REQ = 1'b1;
        wait_done(0, 30, "refetch");
        @(posedge clk);
        #1 F_REQ = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("beats_left", 64'(qb.size()), 64'(0));
        chk("txns_left", 64'(qt.size()), 64'(0));
        chk("w2_beats_left", 64'(qb2.size()), 64'(0));
        chk("w2_txns_left", 64'(qt2.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
